sha_msg_schedule: RTL and testbench

Sequential SHA-256 message-schedule generator sitting directly downstream of `sha_padder`. It accepts one padded 512-bit block and emits the 64 schedule words W[0..63], one per transfer, over a valid/ready stream. The compression-round stage consumes that stream. The block holds a 16-word sliding window, so only one sigma/adder datapath is instantiated.

---
 rtl/sha_msg_schedule.sv | 120 ++++++++++++
 tb/tb_sha_msg_schedule.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule
//   SHA-256 message-schedule generator. Accepts one padded 512-bit block and
//   streams the schedule words W[0..ROUNDS-1], one per valid/ready transfer.
//   A 16-word sliding window feeds a single sigma/adder datapath. On each
//   transfer the window shifts down and the newly computed word enters at
//   the top. Because of this, words 0..15 leave the block unmodified.
//
// Parameters
//   ROUNDS    : words emitted per block (16..64)
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   block     : padded block, word 0 = block[511:480], word 15 = block[31:0]
//   in_valid  : block is valid
//   in_ready  : block accepted on in_valid && in_ready
//   w         : current schedule word (registered)
//   w_idx     : index t of w (registered)
//   w_valid   : w / w_idx valid (decoded from state)
//   w_ready   : consumer accepts on w_valid && w_ready
//   w_last    : high with w_valid when w_idx == ROUNDS-1
//
// Configuration
//   SHA_SCHED_B2B_EN : when defined, a new block may be accepted in the same
//                      cycle as the last-word transfer, so blocks stream with
//                      no idle bubble between them.

module sha_msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] block,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  w,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         w_last
);

  localparam logic [5:0] LP_LAST = 6'(ROUNDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_win [16];
  logic [5:0]  r_t;

  logic        w_xfer;
  logic        w_accept;
  logic [31:0] w_next;

  function automatic logic [31:0] f_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Next window entry; additions wrap modulo 2^32.
  always_comb begin
    w_next = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];
  end

  assign w_xfer = (r_state == S_RUN) && w_ready;

`ifdef SHA_SCHED_B2B_EN
  // in_ready is decoded from state only; the accept itself additionally
  // requires the last word to actually transfer, so a stalled last word
  // never lets a new block overwrite the window.
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_RUN) && (r_t == LP_LAST));
  assign w_accept = in_valid &&
                    ((r_state == S_IDLE) || ((r_state == S_RUN) && (r_t == LP_LAST) && w_ready));
`else
  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && (r_state == S_IDLE);
`endif

  assign w       = r_win[0];
  assign w_idx   = r_t;
  assign w_valid = (r_state == S_RUN);
  assign w_last  = (r_state == S_RUN) && (r_t == LP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        // A load takes priority over the shift of a concurrent last-word transfer.
        for (int unsigned i = 0; i < 16; i++) begin
          r_win[i] <= block[511 - 32*i -: 32];
        end
        r_t     <= '0;
        r_state <= S_RUN;
      end else if (w_xfer) begin
        for (int unsigned i = 0; i < 15; i++) begin
          r_win[i] <= r_win[i+1];
        end
        r_win[15] <= w_next;
        if (r_t == LP_LAST) begin
          r_t     <= '0;
          r_state <= S_IDLE;
        end else begin
          r_t <= r_t + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
module tb_sha_msg_schedule;

`ifdef SHA_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [511:0] block;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  w;
  logic [5:0]   w_idx;
  logic         w_valid;
  logic         w_ready;
  logic         w_last;

  int n_cmp;
  int n_err;
  logic [31:0] cap [64];

  logic [511:0] blk_abc;
  logic [511:0] blk_ones;

  sha_msg_schedule #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .block    (block),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w        (w),
    .w_idx    (w_idx),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_last   (w_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [511:0] b, input string nm);
    @(negedge clk);
    block    = b;
    in_valid = 1'b1;
    w_ready  = 1'b1;
    chk({nm, " start in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Consume one block's words, checking each against a reference schedule
  // computed here in the textbook (non-windowed) form.
  task automatic consume(input logic [511:0] blk, input int gap,
                         input int stall_at, input int stall_n,
                         input int inj_at, input logic [511:0] inj_blk,
                         input int abort_at, input string nm);
    logic [31:0] m [64];
    int k, left, lasts, g, cyc;
    bit seen;
    k = 0; left = stall_n; lasts = 0; g = 0; cyc = 0; seen = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      m[i] = ref_s1(m[i-2]) + m[i-7] + ref_s0(m[i-15]) + m[i-16];
    while (k < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (g < gap) begin
        chk($sformatf("%s gap w_valid", nm), 32'(w_valid), 32'd0);
        chk($sformatf("%s gap in_ready", nm), 32'(in_ready), 32'd1);
        w_ready = 1'b1;
        g++;
        continue;
      end
      chk($sformatf("%s w_valid k=%0d", nm, k), 32'(w_valid), 32'd1);
      if (!w_valid) continue;
      if (!seen) begin
        in_valid = 1'b0;
        seen = 1'b1;
      end
      chk($sformatf("%s w_idx k=%0d", nm, k), 32'(w_idx), 32'(k));
      chk($sformatf("%s w k=%0d", nm, k), w, m[k]);
      if (k == abort_at) return;
      chk($sformatf("%s w_last k=%0d", nm, k), 32'(w_last), 32'(k == 63));
      chk($sformatf("%s in_ready k=%0d", nm, k), 32'(in_ready), 32'(B2B && k == 63));
      if (k == inj_at) begin
        block    = inj_blk;
        in_valid = 1'b1;
      end
      if (k == stall_at && left > 0) begin
        w_ready = 1'b0;
        left--;
      end else begin
        w_ready = 1'b1;
        cap[k]  = w;
        if (w_last) lasts++;
        k++;
      end
    end
    chk({nm, " transfers"}, 32'(k), 32'd64);
    chk({nm, " w_last count"}, 32'(lasts), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; block = '0; in_valid = 1'b0; w_ready = 1'b0;
    blk_abc = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0]    = 32'h00000018;
    blk_ones = '1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst w_valid", 32'(w_valid), 32'd0);
    chk("rst w_last", 32'(w_last), 32'd0);
    chk("rst w", w, 32'd0);
    chk("rst w_idx", 32'(w_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    chk("post-rst w_valid", 32'(w_valid), 32'd0);

    // "abc" block, no stalls, hand-computed words
    start(blk_abc, "abc");
    consume(blk_abc, 0, -1, 0, -1, '0, -1, "abc");
    chk("abc W0", cap[0], 32'h61626380);
    for (int i = 1; i < 15; i++) chk($sformatf("abc W%0d", i), cap[i], 32'h0);
    chk("abc W15", cap[15], 32'h00000018);
    chk("abc W16", cap[16], 32'h61626380);
    chk("abc W17", cap[17], 32'h000F0000);

    // Backpressure: 5 stall cycles while idx 20 is presented
    start(blk_abc, "stall");
    consume(blk_abc, 0, 20, 5, -1, '0, -1, "stall");
    chk("stall W17", cap[17], 32'h000F0000);

    // Wrap arithmetic
    start(blk_ones, "ones");
    consume(blk_ones, 0, -1, 0, -1, '0, -1, "ones");
    for (int i = 0; i < 16; i++) chk($sformatf("ones W%0d", i), cap[i], 32'hFFFFFFFF);
    chk("ones W16", cap[16], 32'h203FFFFC);

    // Second block offered during RUN must not disturb the window
    start(blk_abc, "inj");
    consume(blk_abc, 0, -1, 0, 10, blk_ones, -1, "inj");
    consume(blk_ones, B2B ? 0 : 1, -1, 0, -1, '0, -1, "inj2");

    // Reset while idx 30 is presented
    start(blk_abc, "abort");
    consume(blk_abc, 0, -1, 0, -1, '0, 30, "abort");
    rst = 1'b1;
    #1;
    chk("midrst w_valid", 32'(w_valid), 32'd0);
    chk("midrst w_last", 32'(w_last), 32'd0);
    chk("midrst w", w, 32'd0);
    chk("midrst w_idx", 32'(w_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst idle w_valid", 32'(w_valid), 32'd0);
    start(blk_ones, "restart");
    consume(blk_ones, 0, -1, 0, -1, '0, -1, "restart");
    chk("restart W16", cap[16], 32'h203FFFFC);

`ifdef SHA_SCHED_B2B_EN
    // Back-to-back: second block offered at the last word, no bubble
    start(blk_abc, "b2b");
    consume(blk_abc, 0, -1, 0, 63, blk_ones, -1, "b2b");
    consume(blk_ones, 0, -1, 0, -1, '0, -1, "b2b2");
    chk("b2b2 W16", cap[16], 32'h203FFFFC);
`endif

    @(negedge clk);
    chk("final idle w_valid", 32'(w_valid), 32'd0);
    chk("final in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
